cuckoo_lookup: RTL and testbench

CUCKOO_LOOKUP -- requirements
Module: cuckoo_lookup

---
 rtl/cuckoo_pkg.sv | 23 ++
 rtl/cuckoo_lookup.sv | 196 +++++++++++++++++++
 tb/tb_cuckoo_lookup.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cuckoo_pkg.sv
// Shared definitions for the cuckoo hash table blocks (lookup and inserter):
// default geometry, the lookup FSM state encoding and the table-select encoding.
package cuckoo_pkg;

   localparam int TABLE_DEPTH = 20;
   localparam int KEY_W       = 32;
   localparam int IDX_W       = 5;

   // Table-select encoding used on every sel port
   localparam logic TBL1 = 1'b0;
   localparam logic TBL2 = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD1,
      CHK1,
      RD2,
      CHK2,
      DEL,
      RESP
   } state_t;

endpackage

// File: rtl/cuckoo_lookup.sv
// cuckoo_lookup: looks a key up in the two cuckoo tables, table1 first and
// then table2. It reports where the key was found, and on a hit it can
// optionally ask the table owner to clear that slot.
// Optional feature macro: CUCKOO_DELETE_EN. When defined, a hit on a request
// made with req_del=1 produces a one-cycle clear pulse for the hit slot.
// Without the macro req_del is ignored and the clear port is held at 0.
module cuckoo_lookup #(
   parameter int TABLE_DEPTH = cuckoo_pkg::TABLE_DEPTH,
   parameter int KEY_W       = cuckoo_pkg::KEY_W,
   parameter int IDX_W       = cuckoo_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [KEY_W-1:0] num,
   input  logic [IDX_W-1:0] index1,
   input  logic [IDX_W-1:0] index2,
   input  logic             req_del,
   output logic             tbl_rd_en,
   output logic             tbl_rd_sel,
   output logic [IDX_W-1:0] tbl_rd_addr,
   input  logic [KEY_W-1:0] tbl_rd_data,
   input  logic             tbl_rd_filled,
   output logic             tbl_clr_en,
   output logic             tbl_clr_sel,
   output logic [IDX_W-1:0] tbl_clr_addr,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_hit,
   output logic             resp_tbl,
   output logic [IDX_W-1:0] resp_idx
);

   import cuckoo_pkg::*;

`ifdef CUCKOO_DELETE_EN
   localparam bit DEL_EN = 1'b1;
`else
   localparam bit DEL_EN = 1'b0;
`endif

   state_t           state;
   state_t           nextState;
   logic [KEY_W-1:0] keyReg;
   logic [IDX_W-1:0] idx1Reg;
   logic [IDX_W-1:0] idx2Reg;
   logic             delReg;
   logic             hitReg;
   logic             hitTbl;
   logic [IDX_W-1:0] hitIdx;

   logic             idx1InRange;
   logic             idx2InRange;
   logic             idx2RegInRange;
   logic             dataMatch;
   logic             takeDel;

   // An out-of-range index means that table cannot hold the key. Its read is skipped.
   assign idx1InRange    = 32'(index1) < 32'(TABLE_DEPTH);
   assign idx2InRange    = 32'(index2) < 32'(TABLE_DEPTH);
   assign idx2RegInRange = 32'(idx2Reg) < 32'(TABLE_DEPTH);

   // Read data is valid in the CHK state right after the read. An empty slot never matches.
   assign dataMatch = tbl_rd_filled && (tbl_rd_data == keyReg);
   assign takeDel   = DEL_EN && delReg;

   assign resp_hit = hitReg;
   assign resp_tbl = hitTbl;
   assign resp_idx = hitIdx;

   // State register. A reset abandons any lookup in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Capture the request on accept and record where the key was found.
   always_ff @(posedge clk) begin
      if (reset) begin
         keyReg  <= '0;
         idx1Reg <= '0;
         idx2Reg <= '0;
         delReg  <= 1'b0;
         hitReg  <= 1'b0;
         hitTbl  <= TBL1;
         hitIdx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  keyReg  <= num;
                  idx1Reg <= index1;
                  idx2Reg <= index2;
                  delReg  <= req_del;
                  hitReg  <= 1'b0;
                  hitTbl  <= TBL1;
                  hitIdx  <= '0;
               end
            end
            CHK1: begin
               if (dataMatch) begin
                  hitReg <= 1'b1;
                  hitTbl <= TBL1;
                  hitIdx <= idx1Reg;
               end
            end
            CHK2: begin
               if (dataMatch) begin
                  hitReg <= 1'b1;
                  hitTbl <= TBL2;
                  hitIdx <= idx2Reg;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state logic and Moore outputs: table read/clear commands and handshakes.
   always_comb begin
      nextState    = state;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      tbl_rd_en    = 1'b0;
      tbl_rd_sel   = TBL1;
      tbl_rd_addr  = '0;
      tbl_clr_en   = 1'b0;
      tbl_clr_sel  = TBL1;
      tbl_clr_addr = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (idx1InRange) begin
                  nextState = RD1;
               end else if (idx2InRange) begin
                  nextState = RD2;
               end else begin
                  nextState = RESP;
               end
            end
         end
         RD1: begin
            tbl_rd_en   = 1'b1;
            tbl_rd_sel  = TBL1;
            tbl_rd_addr = idx1Reg;
            nextState   = CHK1;
         end
         CHK1: begin
            if (dataMatch) begin
               nextState = takeDel ? DEL : RESP;
            end else if (idx2RegInRange) begin
               nextState = RD2;
            end else begin
               nextState = RESP;
            end
         end
         RD2: begin
            tbl_rd_en   = 1'b1;
            tbl_rd_sel  = TBL2;
            tbl_rd_addr = idx2Reg;
            nextState   = CHK2;
         end
         CHK2: begin
            if (dataMatch) begin
               nextState = takeDel ? DEL : RESP;
            end else begin
               nextState = RESP;
            end
         end
         DEL: begin
`ifdef CUCKOO_DELETE_EN
            tbl_clr_en   = 1'b1;
            tbl_clr_sel  = hitTbl;
            tbl_clr_addr = hitIdx;
`endif
            nextState = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cuckoo_lookup.sv
// Self-checking bench for cuckoo_lookup. It models both 20-entry tables with
// a one-cycle read latency. It applies a table of directed vectors, then
// hand-written stall, reset and delete sequences, then randomized lookups
// checked against a reference model. Honors CUCKOO_DELETE_EN like the RTL.
module tb_cuckoo_lookup;

   localparam int DEPTH = 20;
`ifdef CUCKOO_DELETE_EN
   localparam int DEL_BUILD = 1;
`else
   localparam int DEL_BUILD = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] num;
   logic [4:0]  index1;
   logic [4:0]  index2;
   logic        req_del;
   logic        tbl_rd_en;
   logic        tbl_rd_sel;
   logic [4:0]  tbl_rd_addr;
   logic [31:0] tbl_rd_data = '0;
   logic        tbl_rd_filled = 1'b0;
   logic        tbl_clr_en;
   logic        tbl_clr_sel;
   logic [4:0]  tbl_clr_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_hit;
   logic        resp_tbl;
   logic [4:0]  resp_idx;

   logic [31:0] t1Key  [DEPTH];
   logic        t1Fill [DEPTH];
   logic [31:0] t2Key  [DEPTH];
   logic        t2Fill [DEPTH];

   int rdCount  = 0;
   int clrCount = 0;
   logic       lastClrSel  = 1'b0;
   logic [4:0] lastClrAddr = '0;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic [31:0] key;
      int          i1;
      int          i2;
      int          s1Idx;
      logic [31:0] s1Key;
      logic        s1Fill;
      int          s2Idx;
      logic [31:0] s2Key;
      logic        s2Fill;
      logic        eHit;
      logic        eTbl;
      int          eIdx;
      int          eLat;
      int          eReads;
   } vec_t;

   vec_t vecs [10];

   cuckoo_lookup #(.TABLE_DEPTH(20), .KEY_W(32), .IDX_W(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .num          (num),
      .index1       (index1),
      .index2       (index2),
      .req_del      (req_del),
      .tbl_rd_en    (tbl_rd_en),
      .tbl_rd_sel   (tbl_rd_sel),
      .tbl_rd_addr  (tbl_rd_addr),
      .tbl_rd_data  (tbl_rd_data),
      .tbl_rd_filled(tbl_rd_filled),
      .tbl_clr_en   (tbl_clr_en),
      .tbl_clr_sel  (tbl_clr_sel),
      .tbl_clr_addr (tbl_clr_addr),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_hit     (resp_hit),
      .resp_tbl     (resp_tbl),
      .resp_idx     (resp_idx)
   );

   always #5 clk = ~clk;

   // Table owner model: one-cycle read return, plus a log of reads and clear pulses
   always @(posedge clk) begin
      tbl_rd_data   <= '0;
      tbl_rd_filled <= 1'b0;
      if (tbl_rd_en) begin
         rdCount <= rdCount + 1;
         if (int'(tbl_rd_addr) < DEPTH) begin
            tbl_rd_data   <= tbl_rd_sel ? t2Key[tbl_rd_addr]  : t1Key[tbl_rd_addr];
            tbl_rd_filled <= tbl_rd_sel ? t2Fill[tbl_rd_addr] : t1Fill[tbl_rd_addr];
         end
      end
      if (tbl_clr_en) begin
         clrCount    <= clrCount + 1;
         lastClrSel  <= tbl_clr_sel;
         lastClrAddr <= tbl_clr_addr;
      end
   end

   // Bound the whole run so that a stuck design cannot hang the simulation
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic clearTables();
      for (int i = 0; i < DEPTH; i++) begin
         t1Key[i]  = '0;
         t1Fill[i] = 1'b0;
         t2Key[i]  = '0;
         t2Fill[i] = 1'b0;
      end
   endtask

   // Reference model: table1 is probed first, then table2. A probe is skipped for an out-of-range index.
   // Latency is one cycle, plus two per table probed, plus one for a delete.
   task automatic predict(input logic [31:0] key, input int i1, input int i2, input logic del,
                          output logic eHit, output logic eTbl, output int eIdx,
                          output int eLat, output int eReads, output int eClrs);
      bit ok1, ok2, h1, h2;
      ok1 = (i1 < DEPTH);
      ok2 = (i2 < DEPTH);
      h1  = ok1 && t1Fill[i1] && (t1Key[i1] == key);
      h2  = !h1 && ok2 && t2Fill[i2] && (t2Key[i2] == key);
      eHit   = h1 || h2;
      eTbl   = h2;
      eIdx   = h1 ? i1 : (h2 ? i2 : 0);
      eReads = int'(ok1) + int'(!h1 && ok2);
      eClrs  = (eHit && del && (DEL_BUILD == 1)) ? 1 : 0;
      eLat   = 1 + 2 * int'(ok1) + 2 * int'(!h1 && ok2) + eClrs;
   endtask

   // Issue one request, wait boundedly for the response, report what came back, then release it.
   task automatic applyStimulus(input logic [31:0] key, input int i1, input int i2, input logic del,
                                output logic gHit, output logic gTbl, output int gIdx,
                                output int gLat, output int gReads, output int gClrs);
      int rd0, cl0;
      @(negedge clk);
      num        = key;
      index1     = 5'(i1);
      index2     = 5'(i2);
      req_del    = del;
      req_valid  = 1'b1;
      resp_ready = 1'b0;
      rd0 = rdCount;
      cl0 = clrCount;
      @(posedge clk);
      #1 req_valid = 1'b0;
      gLat = 1;
      @(negedge clk);
      while (!resp_valid && gLat <= 20) begin
         gLat++;
         @(negedge clk);
      end
      gHit   = resp_hit;
      gTbl   = resp_tbl;
      gIdx   = int'(resp_idx);
      gReads = rdCount - rd0;
      gClrs  = clrCount - cl0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " req_ready"},   32'(req_ready),   32'd1);
      checkOutput({tag, " resp_valid"},  32'(resp_valid),  32'd0);
      checkOutput({tag, " resp_hit"},    32'(resp_hit),    32'd0);
      checkOutput({tag, " resp_tbl"},    32'(resp_tbl),    32'd0);
      checkOutput({tag, " resp_idx"},    32'(resp_idx),    32'd0);
      checkOutput({tag, " tbl_rd_en"},   32'(tbl_rd_en),   32'd0);
      checkOutput({tag, " tbl_clr_en"},  32'(tbl_clr_en),  32'd0);
      checkOutput({tag, " tbl_rd_sel"},  32'(tbl_rd_sel),  32'd0);
      checkOutput({tag, " tbl_rd_addr"}, 32'(tbl_rd_addr), 32'd0);
   endtask

   initial begin
      logic gHit, gTbl;
      int   gIdx, gLat, gReads, gClrs;
      logic eHit, eTbl;
      int   eIdx, eLat, eReads, eClrs;
      int   seenResp;
      int   cl0;

      //          key           i1  i2  s1Idx s1Key          s1F   s2Idx s2Key          s2F   hit   tbl   idx lat reads
      vecs[0] = '{32'd38,       12, 18, 12,   32'd38,        1'b1, 99,   32'd0,         1'b0, 1'b1, 1'b0, 12, 3, 1};
      vecs[1] = '{32'd76,       4,  4,  4,    32'd84,        1'b1, 4,    32'd76,        1'b1, 1'b1, 1'b1, 4,  5, 2};
      vecs[2] = '{32'd93,       17, 13, 99,   32'd0,         1'b0, 99,   32'd0,         1'b0, 1'b0, 1'b0, 0,  5, 2};
      vecs[3] = '{32'd8,        25, 4,  99,   32'd0,         1'b0, 4,    32'd8,         1'b1, 1'b1, 1'b1, 4,  3, 1};
      vecs[4] = '{32'd0,        3,  3,  3,    32'd0,         1'b0, 3,    32'd0,         1'b0, 1'b0, 1'b0, 0,  5, 2};
      vecs[5] = '{32'd5,        20, 31, 99,   32'd0,         1'b0, 99,   32'd0,         1'b0, 1'b0, 1'b0, 0,  1, 0};
      vecs[6] = '{32'hFFFFFFFF, 19, 0,  19,   32'hFFFFFFFF,  1'b1, 99,   32'd0,         1'b0, 1'b1, 1'b0, 19, 3, 1};
      vecs[7] = '{32'h80000000, 7,  2,  7,    32'h80000001,  1'b1, 2,    32'h80000000,  1'b1, 1'b1, 1'b1, 2,  5, 2};
      vecs[8] = '{32'd55,       0,  19, 99,   32'd0,         1'b0, 19,   32'd55,        1'b1, 1'b1, 1'b1, 19, 5, 2};
      vecs[9] = '{32'd10,       5,  20, 5,    32'd9,         1'b1, 99,   32'd0,         1'b0, 1'b0, 1'b0, 0,  3, 1};

      reset      = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      num        = '0;
      index1     = '0;
      index2     = '0;
      req_del    = 1'b0;
      clearTables();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      reset = 1'b0;

      // Directed vectors
      for (int v = 0; v < 10; v++) begin
         clearTables();
         if (vecs[v].s1Idx < DEPTH) begin
            t1Key[vecs[v].s1Idx]  = vecs[v].s1Key;
            t1Fill[vecs[v].s1Idx] = vecs[v].s1Fill;
         end
         if (vecs[v].s2Idx < DEPTH) begin
            t2Key[vecs[v].s2Idx]  = vecs[v].s2Key;
            t2Fill[vecs[v].s2Idx] = vecs[v].s2Fill;
         end
         applyStimulus(vecs[v].key, vecs[v].i1, vecs[v].i2, 1'b0, gHit, gTbl, gIdx, gLat, gReads, gClrs);
         checkOutput($sformatf("vec%0d latency", v), 32'(gLat),   32'(vecs[v].eLat));
         checkOutput($sformatf("vec%0d hit", v),     32'(gHit),   32'(vecs[v].eHit));
         checkOutput($sformatf("vec%0d tbl", v),     32'(gTbl),   32'(vecs[v].eTbl));
         checkOutput($sformatf("vec%0d idx", v),     32'(gIdx),   32'(vecs[v].eIdx));
         checkOutput($sformatf("vec%0d reads", v),   32'(gReads), 32'(vecs[v].eReads));
         checkOutput($sformatf("vec%0d clears", v),  32'(gClrs),  32'd0);
      end

      // Response stall: outputs hold and no new request is taken, even on the release cycle
      clearTables();
      t1Key[4] = 32'd84; t1Fill[4] = 1'b1;
      t2Key[4] = 32'd76; t2Fill[4] = 1'b1;
      @(negedge clk);
      num = 32'd76; index1 = 5'd4; index2 = 5'd4; req_del = 1'b0;
      req_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seenResp = 0;
      for (int c = 0; c < 20 && seenResp == 0; c++) begin
         @(negedge clk);
         if (resp_valid) seenResp = 1;
      end
      checkOutput("stall resp seen", 32'(seenResp), 32'd1);
      num = 32'd38; index1 = 5'd12; index2 = 5'd18;
      req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("stall%0d resp_valid", k), 32'(resp_valid), 32'd1);
         checkOutput($sformatf("stall%0d resp_hit", k),   32'(resp_hit),   32'd1);
         checkOutput($sformatf("stall%0d resp_tbl", k),   32'(resp_tbl),   32'd1);
         checkOutput($sformatf("stall%0d resp_idx", k),   32'(resp_idx),   32'd4);
         checkOutput($sformatf("stall%0d req_ready", k),  32'(req_ready),  32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("release req_ready",  32'(req_ready),  32'd1);
      checkOutput("release rd_en",      32'(tbl_rd_en),  32'd0);
      checkOutput("release resp_valid", 32'(resp_valid), 32'd0);
      req_valid  = 1'b0;
      resp_ready = 1'b0;

      // Reset while in CHK2 abandons the lookup
      clearTables();
      @(negedge clk);
      num = 32'd93; index1 = 5'd17; index2 = 5'd13;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort rd1 en",   32'(tbl_rd_en),   32'd1);
      checkOutput("abort rd1 addr", 32'(tbl_rd_addr), 32'd17);
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort rd2 en",   32'(tbl_rd_en),   32'd1);
      checkOutput("abort rd2 sel",  32'(tbl_rd_sel),  32'd1);
      checkOutput("abort rd2 addr", 32'(tbl_rd_addr), 32'd13);
      @(negedge clk);
      checkOutput("abort chk2 rd_en", 32'(tbl_rd_en), 32'd0);
      reset      = 1'b1;
      resp_ready = 1'b1;
      cl0 = clrCount;
      @(negedge clk);
      checkResetOutputs("abort");
      reset      = 1'b0;
      resp_ready = 1'b0;
      seenResp = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid) seenResp++;
      end
      checkOutput("abort no response", 32'(seenResp), 32'd0);
      checkOutput("abort no clear",    32'(clrCount - cl0), 32'd0);

      // Reset wins over a simultaneous request
      @(negedge clk);
      reset = 1'b1;
      num = 32'd38; index1 = 5'd12; index2 = 5'd18;
      req_valid = 1'b1;
      @(negedge clk);
      checkOutput("prio req_ready", 32'(req_ready), 32'd1);
      checkOutput("prio rd_en",     32'(tbl_rd_en), 32'd0);
      reset     = 1'b0;
      req_valid = 1'b0;

      // Delete request on a table1 hit
      clearTables();
      t1Key[12] = 32'd38; t1Fill[12] = 1'b1;
      applyStimulus(32'd38, 12, 18, 1'b1, gHit, gTbl, gIdx, gLat, gReads, gClrs);
      checkOutput("del latency", 32'(gLat),  32'(3 + DEL_BUILD));
      checkOutput("del hit",     32'(gHit),  32'd1);
      checkOutput("del tbl",     32'(gTbl),  32'd0);
      checkOutput("del idx",     32'(gIdx),  32'd12);
      checkOutput("del clears",  32'(gClrs), 32'(DEL_BUILD));
`ifdef CUCKOO_DELETE_EN
      checkOutput("del clr_sel",  32'(lastClrSel),  32'd0);
      checkOutput("del clr_addr", 32'(lastClrAddr), 32'd12);
`endif

      // Randomized lookups against the reference model
      for (int n = 0; n < 40; n++) begin
         logic [31:0] key;
         int   i1, i2;
         logic del;
         for (int i = 0; i < DEPTH; i++) begin
            t1Fill[i] = 1'($urandom_range(0, 1));
            t1Key[i]  = 32'($urandom_range(0, 7));
            t2Fill[i] = 1'($urandom_range(0, 1));
            t2Key[i]  = 32'($urandom_range(0, 7));
         end
         key = 32'($urandom_range(0, 7));
         i1  = int'($urandom_range(0, 24));
         i2  = int'($urandom_range(0, 24));
         del = 1'($urandom_range(0, 1));
         predict(key, i1, i2, del, eHit, eTbl, eIdx, eLat, eReads, eClrs);
         applyStimulus(key, i1, i2, del, gHit, gTbl, gIdx, gLat, gReads, gClrs);
         checkOutput($sformatf("rnd%0d latency", n), 32'(gLat),   32'(eLat));
         checkOutput($sformatf("rnd%0d hit", n),     32'(gHit),   32'(eHit));
         checkOutput($sformatf("rnd%0d tbl", n),     32'(gTbl),   32'(eTbl));
         checkOutput($sformatf("rnd%0d idx", n),     32'(gIdx),   32'(eIdx));
         checkOutput($sformatf("rnd%0d reads", n),   32'(gReads), 32'(eReads));
         checkOutput($sformatf("rnd%0d clears", n),  32'(gClrs),  32'(eClrs));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
